// File: rtl/ram_block_mover.sv
// Block mover: copies a region of RAM to another region (memmove order) or fills
// a region with a constant, driving a single-port RAM with 1-cycle registered reads.
module ram_block_mover #(
   parameter int addrSize    = 9,
   parameter int contentSize = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic                   mode,
   input  logic [addrSize-1:0]    src_addr,
   input  logic [addrSize-1:0]    dst_addr,
   input  logic [addrSize:0]      length,
   input  logic [contentSize-1:0] fill_value,
   output logic                   busy,
   output logic                   done,
   output logic [addrSize-1:0]    ram_addr,
   output logic [contentSize-1:0] ram_wdata,
   output logic                   ram_write_rq,
   output logic                   ram_output_en,
   input  logic [contentSize-1:0] ram_rdata
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RD     = 2'd1,
      WR     = 2'd2,
      FINISH = 2'd3
   } state_t;

   localparam logic [addrSize-1:0] IDX_ONE = addrSize'(1);
   localparam logic [addrSize:0]   CNT_ONE = (addrSize + 1)'(1);

   state_t                 state, state_nxt;
   logic                   cmd_mode, cmd_mode_nxt;
   logic                   cmd_down, cmd_down_nxt;
   logic [addrSize-1:0]    cmd_src, cmd_src_nxt;
   logic [addrSize-1:0]    cmd_dst, cmd_dst_nxt;
   logic [contentSize-1:0] cmd_fill, cmd_fill_nxt;
   logic [addrSize-1:0]    idx, idx_nxt;
   logic [addrSize:0]      remaining, remaining_nxt;
   logic                   busy_nxt, done_nxt;
   logic [addrSize-1:0]    ram_addr_nxt;
   logic                   write_rq_nxt, output_en_nxt;

   logic                   down_in;
   logic [addrSize-1:0]    first_idx;
   logic [addrSize-1:0]    idx_step;

   // In copy mode the word read in RD arrives on ram_rdata during WR and is written straight back.
   always_comb begin
      ram_wdata = cmd_mode ? cmd_fill : ram_rdata;
   end

   always_comb begin
      state_nxt     = state;
      cmd_mode_nxt  = cmd_mode;
      cmd_down_nxt  = cmd_down;
      cmd_src_nxt   = cmd_src;
      cmd_dst_nxt   = cmd_dst;
      cmd_fill_nxt  = cmd_fill;
      idx_nxt       = idx;
      remaining_nxt = remaining;
      busy_nxt      = busy;
      done_nxt      = 1'b0;
      ram_addr_nxt  = ram_addr;
      write_rq_nxt  = 1'b0;
      output_en_nxt = 1'b0;

      // Overlapping copy towards higher addresses must walk downwards to avoid clobbering its source.
      down_in   = !mode && (dst_addr > src_addr);
      first_idx = down_in ? (length[addrSize-1:0] - IDX_ONE) : '0;
      idx_step  = cmd_down ? (idx - IDX_ONE) : (idx + IDX_ONE);

      case (state)
         IDLE: begin
            if (start) begin
               cmd_mode_nxt  = mode;
               cmd_down_nxt  = down_in;
               cmd_src_nxt   = src_addr;
               cmd_dst_nxt   = dst_addr;
               cmd_fill_nxt  = fill_value;
               idx_nxt       = first_idx;
               remaining_nxt = length;
               if (length == '0) begin
                  state_nxt = FINISH;
                  done_nxt  = 1'b1;
                  busy_nxt  = 1'b0;
               end else if (mode) begin
                  state_nxt    = WR;
                  busy_nxt     = 1'b1;
                  ram_addr_nxt = dst_addr + first_idx;
                  write_rq_nxt = 1'b1;
               end else begin
                  state_nxt     = RD;
                  busy_nxt      = 1'b1;
                  ram_addr_nxt  = src_addr + first_idx;
                  output_en_nxt = 1'b1;
               end
            end
         end
         RD: begin
            state_nxt    = WR;
            ram_addr_nxt = cmd_dst + idx;
            write_rq_nxt = 1'b1;
         end
         WR: begin
            remaining_nxt = remaining - CNT_ONE;
            if (remaining == CNT_ONE) begin
               state_nxt = FINISH;
               done_nxt  = 1'b1;
               busy_nxt  = 1'b0;
            end else begin
               idx_nxt = idx_step;
               if (cmd_mode) begin
                  state_nxt    = WR;
                  ram_addr_nxt = cmd_dst + idx_step;
                  write_rq_nxt = 1'b1;
               end else begin
                  state_nxt     = RD;
                  ram_addr_nxt  = cmd_src + idx_step;
                  output_en_nxt = 1'b1;
               end
            end
         end
         FINISH: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state         <= IDLE;
         cmd_mode      <= 1'b0;
         cmd_down      <= 1'b0;
         cmd_src       <= '0;
         cmd_dst       <= '0;
         cmd_fill      <= '0;
         idx           <= '0;
         remaining     <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         ram_addr      <= '0;
         ram_write_rq  <= 1'b0;
         ram_output_en <= 1'b0;
      end else begin
         state         <= state_nxt;
         cmd_mode      <= cmd_mode_nxt;
         cmd_down      <= cmd_down_nxt;
         cmd_src       <= cmd_src_nxt;
         cmd_dst       <= cmd_dst_nxt;
         cmd_fill      <= cmd_fill_nxt;
         idx           <= idx_nxt;
         remaining     <= remaining_nxt;
         busy          <= busy_nxt;
         done          <= done_nxt;
         ram_addr      <= ram_addr_nxt;
         ram_write_rq  <= write_rq_nxt;
         ram_output_en <= output_en_nxt;
      end
   end

endmodule

// File: tb/tb_ram_block_mover.sv
// Directed bench for ram_block_mover with a registered-read RAM responder and a
// write scoreboard fed from a memmove reference model.
module tb_ram_block_mover;

   typedef struct packed {
      logic [8:0] a;
      logic [7:0] d;
   } wr_t;

   logic       clk;
   logic       reset;
   logic       start;
   logic       mode;
   logic [8:0] src_addr;
   logic [8:0] dst_addr;
   logic [9:0] length;
   logic [7:0] fill_value;
   logic       busy;
   logic       done;
   logic [8:0] ram_addr;
   logic [7:0] ram_wdata;
   logic       ram_write_rq;
   logic       ram_output_en;
   logic [7:0] ram_rdata;

   logic       pl_we;
   logic [8:0] pl_addr;
   logic [7:0] pl_data;
   logic [7:0] mem     [512];
   logic [7:0] ref_mem [512];

   wr_t        exp_q [$];
   logic [8:0] wr_log [$];
   int         total;
   int         bad;
   int         acc_total;
   int         done_cnt;

   ram_block_mover #(.addrSize(9), .contentSize(8)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .mode         (mode),
      .src_addr     (src_addr),
      .dst_addr     (dst_addr),
      .length       (length),
      .fill_value   (fill_value),
      .busy         (busy),
      .done         (done),
      .ram_addr     (ram_addr),
      .ram_wdata    (ram_wdata),
      .ram_write_rq (ram_write_rq),
      .ram_output_en(ram_output_en),
      .ram_rdata    (ram_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single-port RAM: write and registered read share one address.
   always @(posedge clk) begin
      if (pl_we) begin
         mem[pl_addr] <= pl_data;
      end else if (ram_write_rq) begin
         mem[ram_addr] <= ram_wdata;
      end
      if (ram_output_en) begin
         ram_rdata <= mem[ram_addr];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      wr_t e;
      forever begin
         @(negedge clk);
         if (ram_write_rq === 1'b1) begin
            wr_log.push_back(ram_addr);
            if (exp_q.size() == 0) begin
               chk("sb_unexpected_write", 32'(exp_q.size()), 32'd1);
            end else begin
               e = exp_q.pop_front();
               chk("sb_addr", 32'(ram_addr), 32'(e.a));
               chk("sb_data", 32'(ram_wdata), 32'(e.d));
            end
         end
         if (ram_write_rq === 1'b1 || ram_output_en === 1'b1) acc_total++;
         if (ram_write_rq === 1'b1 && ram_output_en === 1'b1) chk("rq_and_oe", 32'd1, 32'd0);
         if (done === 1'b1) done_cnt++;
      end
   end

   task automatic preload(input logic [8:0] a, input logic [7:0] d);
      @(negedge clk);
      pl_we   = 1'b1;
      pl_addr = a;
      pl_data = d;
      ref_mem[a] = d;
      @(posedge clk);
      #1 pl_we = 1'b0;
   endtask

   task automatic push_expected(input logic m, input logic [8:0] s, input logic [8:0] d,
                                input int len, input logic [7:0] fv);
      logic       down;
      logic [8:0] i9;
      wr_t        e;
      down = !m && (d > s);
      for (int k = 0; k < len; k++) begin
         i9  = down ? 9'(len - 1 - k) : 9'(k);
         e.a = d + i9;
         e.d = m ? fv : ref_mem[s + i9];
         ref_mem[e.a] = e.d;
         exp_q.push_back(e);
      end
   endtask

   task automatic run_cmd(input string tag, input logic m, input logic [8:0] s, input logic [8:0] d,
                          input int len, input logic [7:0] fv, input int exp_n,
                          input int poke, input bit fin_poke);
      int n;
      int dn0;
      int acc0;
      push_expected(m, s, d, len, fv);
      dn0  = done_cnt;
      acc0 = acc_total;
      @(negedge clk);
      start = 1'b1; mode = m; src_addr = s; dst_addr = d; length = 10'(len); fill_value = fv;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      mode = ~m; src_addr = s ^ 9'h055; dst_addr = d ^ 9'h0AA; length = 10'd1; fill_value = ~fv;
      n = 1;
      if (len != 0) chk({tag, "_busy_start"}, 32'(busy), 32'd1);
      while (done !== 1'b1 && n < exp_n + 20) begin
         if (n == poke) start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         n++;
      end
      chk({tag, "_done_seen"}, 32'(done), 32'd1);
      chk({tag, "_latency"}, 32'(n), 32'(exp_n));
      chk({tag, "_busy_finish"}, 32'(busy), 32'd0);
      if (fin_poke) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk({tag, "_done_pulse"}, 32'(done), 32'd0);
      repeat (2) @(negedge clk);
      chk({tag, "_busy_after"}, 32'(busy), 32'd0);
      chk({tag, "_done_count"}, 32'(done_cnt - dn0), 32'd1);
      chk({tag, "_accesses"}, 32'(acc_total - acc0), 32'(m ? len : 2 * len));
      chk({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog_timeout observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int nbad;
      int base;
      int dn0;
      total = 0; bad = 0; acc_total = 0; done_cnt = 0;
      reset = 1'b0; start = 1'b0; mode = 1'b0; src_addr = '0; dst_addr = '0;
      length = '0; fill_value = '0; pl_we = 1'b0; pl_addr = '0; pl_data = '0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_addr", 32'(ram_addr), 32'd0);
      chk("rst_write_rq", 32'(ram_write_rq), 32'd0);
      chk("rst_output_en", 32'(ram_output_en), 32'd0);

      for (int a = 0; a < 512; a++) preload(9'(a), 8'h00);
      preload(9'd3, 8'd11); preload(9'd4, 8'd22); preload(9'd5, 8'd33); preload(9'd6, 8'd44);
      preload(9'd10, 8'd1); preload(9'd11, 8'd2); preload(9'd12, 8'd3); preload(9'd13, 8'd4);
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      run_cmd("copy_up", 1'b0, 9'd3, 9'd100, 4, 8'h00, 9, 0, 1'b0);
      chk("copy_up_w100", 32'(mem[100]), 32'd11);
      chk("copy_up_w101", 32'(mem[101]), 32'd22);
      chk("copy_up_w102", 32'(mem[102]), 32'd33);
      chk("copy_up_w103", 32'(mem[103]), 32'd44);
      chk("copy_up_src3", 32'(mem[3]), 32'd11);
      chk("copy_up_src6", 32'(mem[6]), 32'd44);

      base = wr_log.size();
      run_cmd("overlap", 1'b0, 9'd10, 9'd12, 4, 8'h00, 9, 0, 1'b0);
      chk("overlap_first_wr", 32'(wr_log[base]), 32'd15);
      chk("overlap_w12", 32'(mem[12]), 32'd1);
      chk("overlap_w13", 32'(mem[13]), 32'd2);
      chk("overlap_w14", 32'(mem[14]), 32'd3);
      chk("overlap_w15", 32'(mem[15]), 32'd4);

      run_cmd("fill_wrap", 1'b1, 9'd0, 9'd510, 4, 8'hA5, 5, 0, 1'b0);
      chk("fill_wrap_510", 32'(mem[510]), 32'hA5);
      chk("fill_wrap_511", 32'(mem[511]), 32'hA5);
      chk("fill_wrap_0", 32'(mem[0]), 32'hA5);
      chk("fill_wrap_1", 32'(mem[1]), 32'hA5);
      chk("fill_wrap_2", 32'(mem[2]), 32'h00);

      run_cmd("zero_len", 1'b0, 9'd3, 9'd50, 0, 8'h00, 1, 0, 1'b0);

      run_cmd("busy_start", 1'b0, 9'd100, 9'd200, 3, 8'h00, 7, 2, 1'b1);
      chk("busy_start_w200", 32'(mem[200]), 32'd11);
      chk("busy_start_w202", 32'(mem[202]), 32'd33);

      run_cmd("same_addr", 1'b0, 9'd4, 9'd4, 2, 8'h00, 5, 0, 1'b0);
      chk("same_addr_w5", 32'(mem[5]), 32'd33);

      // Reset abort: words 0..3 land before the reset edge, no done pulse follows.
      push_expected(1'b1, 9'd0, 9'd0, 4, 8'h5A);
      dn0 = done_cnt;
      @(negedge clk);
      start = 1'b1; mode = 1'b1; src_addr = 9'd0; dst_addr = 9'd0; length = 10'd8; fill_value = 8'h5A;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_write_rq", 32'(ram_write_rq), 32'd0);
      chk("abort_output_en", 32'(ram_output_en), 32'd0);
      chk("abort_addr", 32'(ram_addr), 32'd0);
      reset = 1'b1;
      repeat (4) @(negedge clk);
      chk("abort_no_done", 32'(done_cnt - dn0), 32'd0);
      chk("abort_w3", 32'(mem[3]), 32'h5A);
      chk("abort_w4_kept", 32'(mem[4]), 32'd22);
      chk("abort_sb_empty", 32'(exp_q.size()), 32'd0);
      run_cmd("post_abort", 1'b1, 9'd0, 9'd20, 2, 8'h77, 3, 0, 1'b0);
      chk("post_abort_w21", 32'(mem[21]), 32'h77);

      run_cmd("full_fill", 1'b1, 9'd0, 9'd0, 512, 8'h3C, 513, 0, 1'b0);
      nbad = 0;
      for (int a = 0; a < 512; a++) if (mem[a] !== 8'h3C) nbad++;
      chk("full_fill_words", 32'(nbad), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
